mult_result_buffer: RTL and testbench

Small FIFO between the single-precision multiplier and the LCD display path. Captures each 32-bit product on the multiplier's `mult_done` pulse, classifies it (zero/denormal/normal/infinity/NaN), splits the IEEE-754 fields, and holds up to `DEPTH` results until the display side pops them. Decouples the fast multiply loop from the slow 1 µs-clocked LCD writer, so no product is lost while a line is being drawn.

---
 rtl/mult_buf_pkg.sv | 28 ++
 rtl/fp_classify.sv | 37 +++
 rtl/mult_result_buffer.sv | 133 +++++++++++++
 tb/tb_mult_result_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_buf_pkg
//  Description : Shared definitions for the multiplier result buffer and the
//                display path: IEEE-754 single-precision field widths, the
//                3-bit result class codes and the default buffer depth.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_buf_pkg;

  localparam int SIGN_W        = 1;
  localparam int EXP_W         = 8;
  localparam int FRAC_W        = 23;
  localparam int WORD_W        = SIGN_W + EXP_W + FRAC_W;
  localparam int CLS_W         = 3;
  localparam int DEFAULT_DEPTH = 4;

  // Codes 5..7 are never produced.
  typedef enum logic [CLS_W-1:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_e;

endpackage : mult_buf_pkg
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational classifier of a single-precision word into
//                zero / denormal / normal / infinity / NaN. Sign is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_classify
  import mult_buf_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [CLS_W-1:0]  cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              exp_zero;
  logic              exp_ones;
  logic              frac_zero;

  assign exp_f     = word[FRAC_W +: EXP_W];
  assign frac_f    = word[FRAC_W-1:0];
  assign exp_zero  = (exp_f == '0);
  assign exp_ones  = (exp_f == '1);
  assign frac_zero = (frac_f == '0);

  // Decode the class from the exponent extremes and the fraction.
  always_comb begin
    cls = CLS_NORMAL;
    if (exp_zero)
      cls = frac_zero ? CLS_ZERO : CLS_DENORM;
    else if (exp_ones)
      cls = frac_zero ? CLS_INF : CLS_NAN;
  end

endmodule : fp_classify
`default_nettype wire

// File: rtl/mult_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_result_buffer
//  Description : First-word-fall-through FIFO between the FP multiplier and
//                the LCD writer. Each product is classified on push; the head
//                entry is presented with its IEEE-754 fields split out and
//                gated to zero when the buffer is empty. Pushes arriving while
//                full (and not matched by a pop) are dropped and latched in a
//                sticky overflow flag.
//  Options     : MULT_BUF_STATS_EN - adds saturating total_cnt / nan_cnt
//                counters of accepted pushes.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_result_buffer
  import mult_buf_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 2
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_done,
  input  logic [WORD_W-1:0] product,
  input  logic              pop,
  input  logic              ovf_clear,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_product,
  output logic [SIGN_W-1:0] rd_sign,
  output logic [EXP_W-1:0]  rd_exp,
  output logic [FRAC_W-1:0] rd_frac,
  output logic [CLS_W-1:0]  rd_class,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
`ifdef MULT_BUF_STATS_EN
  ,
  output logic [15:0]       total_cnt,
  output logic [15:0]       nan_cnt
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WORD_W-1:0] mem_word [DEPTH];
  logic [CLS_W-1:0]  mem_cls  [DEPTH];

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;

  logic [CLS_W-1:0]  push_cls;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;

  fp_classify u_classify (
    .word (product),
    .cls  (push_cls)
  );

  // A pop frees a slot in the same cycle, so a full buffer may still accept
  // a push that coincides with a valid pop.
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_ok   = pop && rd_valid;
  assign push_ok  = mult_done && (!full || pop_ok);
  assign drop     = mult_done && !push_ok;

  // Storage is deliberately not reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_word[wptr] <= product;
      mem_cls[wptr]  <= push_cls;
    end
  end

  // Pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      if (push_ok && !pop_ok)
        count_q <= count_q + CNT_ONE;
      else if (pop_ok && !push_ok)
        count_q <= count_q - CNT_ONE;
      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clear)
        ovf_q <= 1'b0;
    end
  end

  // Head entry falls through, forced to zero when nothing is held.
  always_comb begin
    rd_product = '0;
    rd_class   = '0;
    if (rd_valid) begin
      rd_product = mem_word[rptr];
      rd_class   = mem_cls[rptr];
    end
  end

  assign rd_sign  = rd_product[WORD_W-1 -: SIGN_W];
  assign rd_exp   = rd_product[FRAC_W +: EXP_W];
  assign rd_frac  = rd_product[FRAC_W-1:0];
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef MULT_BUF_STATS_EN
  // Saturating counters of accepted pushes; dropped words are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cnt <= '0;
      nan_cnt   <= '0;
    end else if (push_ok) begin
      if (total_cnt != 16'hFFFF)
        total_cnt <= total_cnt + 16'd1;
      if ((push_cls == CLS_NAN) && (nan_cnt != 16'hFFFF))
        nan_cnt <= nan_cnt + 16'd1;
    end
  end
`endif

endmodule : mult_result_buffer
`default_nettype wire

// File: tb/tb_mult_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_result_buffer
//  Description : Self-checking bench for mult_result_buffer. A classification
//                vector table, hand sequences for full/empty/reset corners and
//                a randomized phase, all checked against a queue-based model.
//                Compile with +define+MULT_BUF_STATS_EN to check the counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_result_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_done;
  logic [31:0] product;
  logic        pop;
  logic        ovf_clear;
  logic        rd_valid;
  logic [31:0] rd_product;
  logic        rd_sign;
  logic [7:0]  rd_exp;
  logic [22:0] rd_frac;
  logic [2:0]  rd_class;
  logic [ADDR_W:0] count;
  logic        full;
  logic        overflow;
`ifdef MULT_BUF_STATS_EN
  logic [15:0] total_cnt;
  logic [15:0] nan_cnt;
`endif

  always #5 clk = ~clk;

  mult_result_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_done  (mult_done),
    .product    (product),
    .pop        (pop),
    .ovf_clear  (ovf_clear),
    .rd_valid   (rd_valid),
    .rd_product (rd_product),
    .rd_sign    (rd_sign),
    .rd_exp     (rd_exp),
    .rd_frac    (rd_frac),
    .rd_class   (rd_class),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
`ifdef MULT_BUF_STATS_EN
    ,
    .total_cnt  (total_cnt),
    .nan_cnt    (nan_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic        m_ovf;
  int unsigned m_total;
  int unsigned m_nan;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [2:0] ref_class(input logic [31:0] w);
    int e;
    int f;
    e = int'(w[30:23]);
    f = int'(w[22:0]);
    if (e == 0)   return (f == 0) ? 3'd0 : 3'd1;
    if (e == 255) return (f == 0) ? 3'd3 : 3'd4;
    return 3'd2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (q.size() > 0) ? q[0] : 32'h0;
    chk({tag, ".rd_valid"},   32'(rd_valid),   32'(q.size() > 0));
    chk({tag, ".rd_product"}, rd_product,      head);
    chk({tag, ".rd_sign"},    32'(rd_sign),    32'(head[31]));
    chk({tag, ".rd_exp"},     32'(rd_exp),     32'(head[30:23]));
    chk({tag, ".rd_frac"},    32'(rd_frac),    32'(head[22:0]));
    chk({tag, ".rd_class"},   32'(rd_class),   (q.size() > 0) ? 32'(ref_class(head)) : 32'h0);
    chk({tag, ".count"},      32'(count),      32'(q.size()));
    chk({tag, ".full"},       32'(full),       32'(q.size() == DEPTH));
    chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
`ifdef MULT_BUF_STATS_EN
    chk({tag, ".total_cnt"},  32'(total_cnt),  m_total);
    chk({tag, ".nan_cnt"},    32'(nan_cnt),    m_nan);
`endif
  endtask

  // One clock: present strobes, update the model at the edge, release strobes.
  task automatic tick(input logic md, input logic [31:0] prod, input logic pp, input logic oc);
    bit pop_eff;
    bit push_eff;
    mult_done = md;
    product   = prod;
    pop       = pp;
    ovf_clear = oc;
    @(posedge clk);
    pop_eff  = pp && (q.size() > 0);
    push_eff = md && ((q.size() < DEPTH) || pop_eff);
    if (pop_eff) void'(q.pop_front());
    if (push_eff) begin
      q.push_back(prod);
      if (m_total < 32'hFFFF) m_total++;
      if (ref_class(prod) == 3'd4 && m_nan < 32'hFFFF) m_nan++;
    end
    if (md && !push_eff) m_ovf = 1'b1;
    else if (oc)         m_ovf = 1'b0;
    #1;
    mult_done = 1'b0;
    pop       = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_total = 0;
    m_nan   = 0;
  endtask

  // Asynchronous assertion mid-cycle, release away from the clock edge.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- classification vectors ----------------
  typedef struct {
    logic [31:0] word;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [2:0]  cls;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within %0d ns, expected completion", 1_000_000);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h3F800000, 1'b0, 8'h7F, 23'h000000, 3'd2};
    vecs[1] = '{32'h00000000, 1'b0, 8'h00, 23'h000000, 3'd0};
    vecs[2] = '{32'h80000000, 1'b1, 8'h00, 23'h000000, 3'd0};
    vecs[3] = '{32'h00000001, 1'b0, 8'h00, 23'h000001, 3'd1};
    vecs[4] = '{32'h807FFFFF, 1'b1, 8'h00, 23'h7FFFFF, 3'd1};
    vecs[5] = '{32'h7F800000, 1'b0, 8'hFF, 23'h000000, 3'd3};
    vecs[6] = '{32'hFF800000, 1'b1, 8'hFF, 23'h000000, 3'd3};
    vecs[7] = '{32'h7FC00000, 1'b0, 8'hFF, 23'h400000, 3'd4};
    vecs[8] = '{32'h00800000, 1'b0, 8'h01, 23'h000000, 3'd2};
    vecs[9] = '{32'hC0490FDB, 1'b1, 8'h80, 23'h490FDB, 3'd2};

    reset     = 1'b0;
    mult_done = 1'b0;
    product   = 32'h0;
    pop       = 1'b0;
    ovf_clear = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_all("in_reset");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_reset");

    // Table: push one word, compare split fields, pop it back out
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, vecs[i].word, 1'b0, 1'b0);
      chk($sformatf("vec%0d.valid", i),   32'(rd_valid),   32'h1);
      chk($sformatf("vec%0d.product", i), rd_product,      vecs[i].word);
      chk($sformatf("vec%0d.sign", i),    32'(rd_sign),    32'(vecs[i].sign));
      chk($sformatf("vec%0d.exp", i),     32'(rd_exp),     32'(vecs[i].exp));
      chk($sformatf("vec%0d.frac", i),    32'(rd_frac),    32'(vecs[i].frac));
      chk($sformatf("vec%0d.class", i),   32'(rd_class),   32'(vecs[i].cls));
      chk($sformatf("vec%0d.count", i),   32'(count),      32'h1);
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      check_all($sformatf("vec%0d.popped", i));
    end

    // Four special values: full after the fourth, pops return 0,1,3,4
    tick(1'b1, 32'h00000000, 1'b0, 1'b0);
    tick(1'b1, 32'h00000001, 1'b0, 1'b0);
    tick(1'b1, 32'h7F800000, 1'b0, 1'b0);
    chk("spec.full_at3", 32'(full), 32'h0);
    tick(1'b1, 32'h7FC00000, 1'b0, 1'b0);
    chk("spec.full_at4",  32'(full),  32'h1);
    chk("spec.count_at4", 32'(count), 32'h4);
    begin
      logic [2:0] exp_cls [4];
      exp_cls[0] = 3'd0; exp_cls[1] = 3'd1; exp_cls[2] = 3'd3; exp_cls[3] = 3'd4;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("spec.pop%0d.class", i), 32'(rd_class), 32'(exp_cls[i]));
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check_all($sformatf("spec.pop%0d", i));
      end
    end

    // Overflow: fill, push while full, then clear
    tick(1'b1, 32'h3F800000, 1'b0, 1'b0);
    tick(1'b1, 32'h3FC00000, 1'b0, 1'b0);
    tick(1'b1, 32'h40800000, 1'b0, 1'b0);
    tick(1'b1, 32'h40A00000, 1'b0, 1'b0);
    tick(1'b1, 32'h40000000, 1'b0, 1'b0);
    chk("ovf.flag",  32'(overflow), 32'h1);
    chk("ovf.count", 32'(count),    32'h4);
    chk("ovf.head",  rd_product,    32'h3F800000);
    check_all("ovf.after_drop");
    // Dropping push together with clear: set wins
    tick(1'b1, 32'h41000000, 1'b0, 1'b1);
    chk("ovf.set_wins", 32'(overflow), 32'h1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf.cleared", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      check_all($sformatf("ovf.drain%0d", i));
    end

    // Full with simultaneous push and pop: count stays, no overflow
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0);
    tick(1'b1, 32'h40400000, 1'b1, 1'b0);
    chk("fullpp.count",    32'(count),    32'h4);
    chk("fullpp.overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullpp.last", rd_product, 32'h40400000);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    check_all("fullpp.empty");

    // Empty: push and pop together accepts the push
    tick(1'b1, 32'h40E00000, 1'b1, 1'b0);
    chk("emptypp.count", 32'(count),    32'h1);
    chk("emptypp.head",  rd_product,    32'h40E00000);
    tick(1'b0, 32'h0, 1'b1, 1'b0);

    // Pop on empty is ignored
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("underflow.count", 32'(count),    32'h0);
    chk("underflow.valid", 32'(rd_valid), 32'h0);
    tick(1'b1, 32'h41100000, 1'b0, 1'b0);
    chk("underflow.push_head", rd_product, 32'h41100000);

    // Reset mid-stream with three entries
    tick(1'b1, 32'h41200000, 1'b0, 1'b0);
    tick(1'b1, 32'h41300000, 1'b0, 1'b0);
    chk("midrst.count_before", 32'(count), 32'h3);
    apply_reset("midrst");
    chk("midrst.valid", 32'(rd_valid), 32'h0);
    chk("midrst.count", 32'(count),    32'h0);
    check_all("midrst.released");

`ifdef MULT_BUF_STATS_EN
    // Counters: NaN plus normals accepted, one dropped push not counted
    tick(1'b1, 32'h7FC00001, 1'b0, 1'b0);
    tick(1'b1, 32'h3F800000, 1'b0, 1'b0);
    tick(1'b1, 32'h40000000, 1'b0, 1'b0);
    chk("stats.total3", 32'(total_cnt), 32'h3);
    chk("stats.nan1",   32'(nan_cnt),   32'h1);
    tick(1'b1, 32'h40400000, 1'b0, 1'b0);
    tick(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("stats.total_drop", 32'(total_cnt), 32'h4);
    chk("stats.nan_drop",   32'(nan_cnt),   32'h1);
    apply_reset("stats.rst");
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [31:0] w;
      int sel;
      sel = int'($urandom_range(0, 7));
      w = $urandom;
      case (sel)
        0: w = {w[31], 31'h0};
        1: w = {w[31], 8'h00, w[22:0] | 23'h1};
        2: w = {w[31], 8'hFF, 23'h0};
        3: w = {w[31], 8'hFF, w[22:0] | 23'h1};
        default: ;
      endcase
      tick(($urandom % 2) == 0, w, ($urandom % 5) < 2, ($urandom % 20) == 0);
      check_all($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mult_result_buffer
`default_nettype wire
